// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, opcodes,
// funct codes, ALU operations, datapath select values and the registered control word.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_LW  = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_TRAP   = 4'd15
    } state_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCS_REG_A  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_REG_B   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] RDST_RT = 2'b00;
    localparam logic [SEL_W-1:0] RDST_RD = 2'b01;
    localparam logic [SEL_W-1:0] RDST_RA = 2'b11;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    // Every registered control output except the branch-conditional PC write.
    typedef struct packed {
        logic             pc_write;
        logic [SEL_W-1:0] pc_source;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             aluout_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        alu_op_e          alu_op;
        logic [SEL_W-1:0] reg_dst_sel;
        logic [SEL_W-1:0] mem_to_reg;
        logic             reg_write;
        logic             trap;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_funct_decode.sv
// R-type funct decoder: ALU operation, legal-arithmetic flag and jr detection.
module mc_funct_decode
    import mc_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                valid,
    output logic                is_jr
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b0;
        is_jr  = 1'b0;
        case (funct)
            FN_ADD: begin alu_op = ALU_ADD; valid = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; valid = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; valid = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  valid = 1'b1; end
            FN_SLT: begin alu_op = ALU_SLT; valid = 1'b1; end
            FN_JR:  is_jr = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit. Control outputs are registered from the
// next state so they line up with state_dbg; only pc_write_cond follows zero live.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [SEL_W-1:0]    pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                aluout_write,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [SEL_W-1:0]    reg_dst_sel,
    output logic [SEL_W-1:0]    mem_to_reg,
    output logic                reg_write,
    output logic                trap,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam int unsigned     CNT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              bne_q, bne_d;
    logic              mem_last;
    logic              mem_last_d;

    logic [ALU_OP_W-1:0] fn_alu_op;
    logic                fn_valid;
    logic                fn_is_jr;

    mc_funct_decode u_funct_decode (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .valid  (fn_valid),
        .is_jr  (fn_is_jr)
    );

    assign mem_last = (cnt_q == CNT_LAST);

    // Next state, wait counter, and the control word belonging to the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        bne_d      = bne_q;
        ctrl_d     = CTRL_IDLE;
        mem_last_d = 1'b0;

        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem_last) state_d = S_DECODE;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DECODE: begin
                bne_d = (opcode == OP_BNE);
                case (opcode)
                    OP_RTYPE:       state_d = fn_is_jr ? S_JR : (fn_valid ? S_EXEC_R : S_TRAP);
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   state_d = S_FETCH;
            S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_last) state_d = S_WB_LW;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WB_LW:  state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_last) state_d = S_FETCH;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase

        mem_last_d = (cnt_d == CNT_LAST);

        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.i_or_d    = 1'b0;
                ctrl_d.alu_src_a = 1'b0;
                ctrl_d.alu_src_b = SRCB_FOUR;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.pc_source = PCS_ALU;
                ctrl_d.ir_write  = mem_last_d;
                ctrl_d.pc_write  = mem_last_d;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b    = SRCB_IMM_SH2;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a    = 1'b1;
                ctrl_d.alu_src_b    = SRCB_REG_B;
                ctrl_d.alu_op       = alu_op_e'(fn_alu_op);
                ctrl_d.aluout_write = 1'b1;
            end
            S_WB_R: begin
                ctrl_d.reg_dst_sel = RDST_RD;
                ctrl_d.mem_to_reg  = M2R_ALUOUT;
                ctrl_d.reg_write   = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                ctrl_d.alu_src_a    = 1'b1;
                ctrl_d.alu_src_b    = SRCB_IMM;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            S_WB_I: begin
                ctrl_d.reg_dst_sel = RDST_RT;
                ctrl_d.mem_to_reg  = M2R_ALUOUT;
                ctrl_d.reg_write   = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_d.i_or_d   = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            S_WB_LW: begin
                ctrl_d.reg_dst_sel = RDST_RT;
                ctrl_d.mem_to_reg  = M2R_MDR;
                ctrl_d.reg_write   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REG_B;
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.pc_source = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = PCS_JUMP;
            end
            S_JAL: begin
                ctrl_d.pc_write    = 1'b1;
                ctrl_d.pc_source   = PCS_JUMP;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.reg_dst_sel = RDST_RA;
                ctrl_d.mem_to_reg  = M2R_PC;
            end
            S_JR: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = PCS_REG_A;
            end
            S_TRAP:  ctrl_d.trap = 1'b1;
            default: ;
        endcase
    end

    // State, counter, branch sense and control word; reset also aborts any memory access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            bne_q   <= bne_d;
        end
    end

    // zero is only meaningful during BRANCH, so the conditional write follows it directly.
    assign pc_write_cond = (state_q == S_BRANCH) && (zero != bne_q);

    assign pc_write     = ctrl_q.pc_write;
    assign pc_source    = ctrl_q.pc_source;
    assign i_or_d       = ctrl_q.i_or_d;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign ir_write     = ctrl_q.ir_write;
    assign aluout_write = ctrl_q.aluout_write;
    assign alu_src_a    = ctrl_q.alu_src_a;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign alu_op       = ctrl_q.alu_op;
    assign reg_dst_sel  = ctrl_q.reg_dst_sel;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign reg_write    = ctrl_q.reg_write;
    assign trap         = ctrl_q.trap;
    assign state_dbg    = state_q;

endmodule
